// File: rtl/cic_decimator.sv
// CIC decimator: 1-bit sigma-delta stream in, signed PCM words out at 1/DECIMATION rate.
// Integrators run on every ena_in; the comb chain is evaluated once per decimation tick.
module cic_decimator #(
   parameter int unsigned ORDER      = 3,
   parameter int unsigned DECIMATION = 64,
   parameter int unsigned OUT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena_in,
   input  logic                 data_in,
   output logic [OUT_WIDTH-1:0] data_out,
   output logic                 data_valid
);

   localparam int unsigned CW = $clog2(DECIMATION);
   localparam int unsigned W  = 2 + ORDER * CW;

   localparam logic [CW-1:0] CntMax  = CW'(DECIMATION - 1);
   localparam logic [2:0]    WarmMax = 3'(ORDER);

   logic [W-1:0]         r_integ [ORDER];
   logic [W-1:0]         r_dly   [ORDER];
   logic [CW-1:0]        r_cnt;
   logic [2:0]           r_warm;
   logic [OUT_WIDTH-1:0] r_data_out;
   logic                 r_valid;

   logic [W-1:0]         w_x;
   logic                 w_tick;
   logic [W-1:0]         w_cin [ORDER];
   logic [W-1:0]         w_cout;
   logic [OUT_WIDTH-1:0] w_scaled;

   // Bit 1 -> +1, bit 0 -> -1 (all ones).
   assign w_x    = data_in ? W'(1) : '1;
   assign w_tick = ena_in && (r_cnt == CntMax);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < ORDER; k++) begin
            r_integ[k] <= '0;
         end
      end else if (ena_in) begin
         r_integ[0] <= r_integ[0] + w_x;
         for (int k = 1; k < ORDER; k++) begin
            r_integ[k] <= r_integ[k] + r_integ[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (ena_in) begin
         r_cnt <= (r_cnt == CntMax) ? '0 : r_cnt + CW'(1);
      end
   end

   // Comb chain from the last integrator; w_cin[k] is the input to stage k.
   always_comb begin : comb_chain
      logic [W-1:0] w_acc;
      w_acc = r_integ[ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
         w_cin[k] = w_acc;
         w_acc    = w_acc - r_dly[k];
      end
      w_cout = w_acc;
   end

   generate
      if (OUT_WIDTH >= W) begin : g_extend
         assign w_scaled = OUT_WIDTH'($signed(w_cout));
      end else begin : g_truncate
         assign w_scaled = w_cout[W-1 -: OUT_WIDTH];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < ORDER; k++) begin
            r_dly[k] <= '0;
         end
         r_warm     <= '0;
         r_data_out <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_tick) begin
            for (int k = 0; k < ORDER; k++) begin
               r_dly[k] <= w_cin[k];
            end
            r_data_out <= w_scaled;
            // Strobe only once every comb delay holds a real sample.
            r_valid    <= (r_warm == WarmMax);
            if (r_warm != WarmMax) begin
               r_warm <= r_warm + 3'd1;
            end
         end
      end
   end

   assign data_out   = r_data_out;
   assign data_valid = r_valid;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: full-scale, duty-cycle, truncation, reset and gating cases.
module tb_cic_decimator;

   logic        clk;
   logic        rst;
   logic        ena_in;
   logic        data_in;
   logic [31:0] dout32;
   logic [15:0] dout16;
   logic [23:0] dout24;
   logic        valid32;
   logic        valid16;
   logic        valid24;

   int errors;
   int checks;

   // Reference decimation phase and tick count since reset.
   int b_cnt;
   int b_ticks;
   int n_en;
   int n_strobe;
   int first_en;
   int clk_n;
   int last_clk;
   int spacing;
   logic        val_on;
   logic signed [31:0] exp_val;

   cic_decimator u_dut (
      .clk        (clk),
      .rst        (rst),
      .ena_in     (ena_in),
      .data_in    (data_in),
      .data_out   (dout32),
      .data_valid (valid32)
   );

   cic_decimator #(.OUT_WIDTH(16)) u_dut16 (
      .clk        (clk),
      .rst        (rst),
      .ena_in     (ena_in),
      .data_in    (data_in),
      .data_out   (dout16),
      .data_valid (valid16)
   );

   cic_decimator #(.OUT_WIDTH(24)) u_dut24 (
      .clk        (clk),
      .rst        (rst),
      .ena_in     (ena_in),
      .data_in    (data_in),
      .data_out   (dout24),
      .data_valid (valid24)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_dout32"}, dout32, 32'h0);
      check({tag, "_dout16"}, {16'h0, dout16}, 32'h0);
      check({tag, "_dout24"}, {8'h0, dout24}, 32'h0);
      check({tag, "_valid"}, {31'h0, valid32}, 32'h0);
   endtask

   task automatic clear_model();
      b_cnt    = 0;
      b_ticks  = 0;
      n_en     = 0;
      n_strobe = 0;
      first_en = -1;
      last_clk = -1;
   endtask

   // Asynchronous reset pulse placed mid-cycle, held across one rising edge.
   task automatic async_reset(input string tag);
      #3 rst = 1'b1;
      #1 check_zero_outputs(tag);
      @(posedge clk);
      #4 rst = 1'b0;
      clear_model();
   endtask

   task automatic cyc(input logic e, input logic d);
      logic tick;
      logic exp_valid;
      ena_in = e;
      data_in = d;
      tick = 1'b0;
      if (e) begin
         n_en++;
         if (b_cnt == 63) begin
            tick = 1'b1;
            b_cnt = 0;
            b_ticks++;
         end else begin
            b_cnt++;
         end
      end
      exp_valid = tick && (b_ticks > 3);
      @(posedge clk);
      #1;
      clk_n++;
      check("valid32", {31'h0, valid32}, {31'h0, exp_valid});
      check("valid16", {31'h0, valid16}, {31'h0, exp_valid});
      if (valid32) begin
         n_strobe++;
         if (n_strobe == 1) first_en = n_en;
         if (spacing != 0 && last_clk >= 0) check("spacing", 32'(clk_n - last_clk), 32'(spacing));
         last_clk = clk_n;
         if (val_on && b_ticks >= 5) begin
            check("dout32", dout32, exp_val);
            check("dout16", {{16{dout16[15]}}, dout16}, exp_val >>> 4);
            check("dout24", {{8{dout24[23]}}, dout24}, exp_val);
         end
      end
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      clk_n   = 0;
      spacing = 0;
      val_on  = 1'b0;
      exp_val = '0;
      rst     = 1'b1;
      ena_in  = 1'b1;
      data_in = 1'b1;
      clear_model();
      #12 check_zero_outputs("reset");
      @(posedge clk);
      #4 rst = 1'b0;

      // Constant 1, enable every cycle.
      spacing = 64;
      val_on  = 1'b1;
      exp_val = 32'sd262144;
      for (int i = 0; i < 448; i++) cyc(1'b1, 1'b1);
      check("c1_strobes", 32'(n_strobe), 32'd4);
      check("c1_first", 32'(first_en), 32'd256);

      // Idle: everything holds.
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
      check("idle_hold", dout32, 32'd262144);

      // Mid-operation reset at cnt=37, then a fresh constant-1 run.
      for (int i = 0; i < 37; i++) cyc(1'b1, 1'b1);
      check("pre_rst_cnt", 32'(b_cnt), 32'd37);
      async_reset("midrst");
      for (int i = 0; i < 320; i++) cyc(1'b1, 1'b1);
      check("rst_strobes", 32'(n_strobe), 32'd2);
      check("rst_first", 32'(first_en), 32'd256);

      // Constant 0.
      async_reset("rst_c0");
      exp_val = -32'sd262144;
      for (int i = 0; i < 448; i++) cyc(1'b1, 1'b0);
      check("c0_last", dout32, 32'hFFFC0000);
      check("c0_strobes", 32'(n_strobe), 32'd4);

      // Alternating bits, enable every 4th clk.
      async_reset("rst_alt");
      spacing = 256;
      exp_val = 32'sd0;
      for (int i = 0; i < 448; i++) begin
         cyc(1'b1, (i % 2) == 0);
         for (int j = 0; j < 3; j++) cyc(1'b0, 1'b0);
      end
      check("alt_strobes", 32'(n_strobe), 32'd4);

      // 75% ones.
      async_reset("rst_75");
      spacing = 64;
      exp_val = 32'sd131072;
      for (int i = 0; i < 448; i++) cyc(1'b1, (i % 4) != 3);
      check("d75_last", dout32, 32'd131072);

      // 25% ones.
      async_reset("rst_25");
      exp_val = -32'sd131072;
      for (int i = 0; i < 448; i++) cyc(1'b1, (i % 4) == 0);
      check("d25_last", dout32, 32'hFFFE0000);

      // Random enable gaps of 0..7 clks, constant 1.
      async_reset("rst_gap");
      spacing = 0;
      exp_val = 32'sd262144;
      for (int i = 0; i < 468; i++) begin
         cyc(1'b1, 1'b1);
         repeat ($urandom_range(0, 7)) cyc(1'b0, 1'b1);
      end
      check("gap_strobes", 32'(n_strobe), 32'd4);
      check("gap_last", dout32, 32'd262144);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
